// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - SPI/host arbiter for the single-port data memory behind the SPI slave
// Optional feature macro: SPI_PRIORITY_EN (fixed SPI priority instead of round robin on a tie).
module spi_mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_SPI  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic grant_valid;
  logic grant_host;

  // Pick the winner among the pending requests (only consumed in IDLE)
  always_comb begin
    grant_valid = spi_req | host_req;
`ifdef SPI_PRIORITY_EN
    // SPI always wins; last_owner is still tracked but plays no part here
    grant_host = ~spi_req;
`else
    // Round robin: on a tie the side that did not own the last access wins
    grant_host = host_req & (~spi_req | (last_owner_q == OWN_SPI));
`endif
  end

  // Transaction sequencer: IDLE samples a request, ACCESS strobes memory, RESP acks
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    spi_rdata_d  = spi_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_host;
          last_owner_d = grant_host;
          we_d         = grant_host ? host_we    : spi_we;
          addr_d       = grant_host ? host_addr  : spi_addr;
          wdata_d      = grant_host ? host_wdata : spi_wdata;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        // Read data arrives the cycle after the strobe; keep it for the owner only
        if (!we_q) begin
          if (owner_q == OWN_HOST) begin
            host_rdata_d = mem_rdata;
          end else begin
            spi_rdata_d = mem_rdata;
          end
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-request registers; reset leaves SPI winning the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_SPI;
      last_owner_q <= OWN_HOST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      spi_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      spi_rdata_q  <= spi_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Output decode; strobes come straight from state so reset drops them at once
  always_comb begin
    mem_en     = (state_q == S_ACCESS);
    mem_we     = mem_en & we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    busy       = (state_q != S_IDLE);
    spi_ack    = (state_q == S_RESP) & (owner_q == OWN_SPI);
    host_ack   = (state_q == S_RESP) & (owner_q == OWN_HOST);
    // Fresh read data is forwarded in the ack cycle, then held from the register
    spi_rdata  = (spi_ack & ~we_q)  ? mem_rdata : spi_rdata_q;
    host_rdata = (host_ack & ~we_q) ? mem_rdata : host_rdata_q;
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - self-checking bench for spi_mem_arbiter
module tb_spi_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_req = 1'b0, spi_we = 1'b0;
  logic [6:0] spi_addr = '0;
  logic [7:0] spi_wdata = '0;
  logic       spi_ack;
  logic [7:0] spi_rdata;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [6:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       mem_en, mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       busy;

  logic [7:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  bit         cap_en;
  logic       cap_we;
  logic [6:0] cap_addr;
  logic [7:0] cap_wd;
  int         cap_cyc;

  typedef struct {
    bit         sr;
    bit         sw;
    logic [6:0] sa;
    logic [7:0] sd;
    bit         hr;
    bit         hw;
    logic [6:0] ha;
    logic [7:0] hd;
    bit         host_first;
    logic [7:0] srd;
    logic [7:0] hrd;
  } vec_t;

  vec_t vecs [7];

  spi_mem_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for an ack; side: 0=spi 1=host 2=both -1=timeout
  task automatic wait_ack(input bit drop, output int side, output int cyc);
    side = -1;
    cyc = 0;
    cap_en = 0;
    while (side < 0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        cap_en = 1;
        cap_we = mem_we;
        cap_addr = mem_addr;
        cap_wd = mem_wdata;
        cap_cyc = cyc;
      end
      if (spi_ack && host_ack) side = 2;
      else if (spi_ack) side = 0;
      else if (host_ack) side = 1;
    end
    if (drop && side == 0) spi_req = 1'b0;
    if (drop && side == 1) host_req = 1'b0;
  endtask

  task automatic check_txn(input string nm, input int side, input int cyc, input int exp_side,
                           input int exp_cyc, input logic we, input logic [6:0] a,
                           input logic [7:0] d);
    chk({nm, "_side"}, side, exp_side);
    chk({nm, "_cyc"}, cyc, exp_cyc);
    chk({nm, "_mem_en"}, {31'd0, cap_en}, 32'd1);
    chk({nm, "_mem_en_cyc"}, cap_cyc, exp_cyc - 1);
    chk({nm, "_mem_we"}, {31'd0, cap_we}, {31'd0, we});
    chk({nm, "_mem_addr"}, {25'd0, cap_addr}, {25'd0, a});
    if (we) chk({nm, "_mem_wdata"}, {24'd0, cap_wd}, {24'd0, d});
  endtask

  initial begin
    int side, cyc;
    bit first_host;
    logic [7:0] prev_srd, prev_hrd;
    int exp_seq [4];

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    //             sr sw sa     sd     hr hw ha     hd     hf srd    hrd
    vecs[0] = '{1, 1, 7'h12, 8'hA5, 0, 0, 7'h00, 8'h00, 0, 8'h00, 8'h00};
    vecs[1] = '{0, 0, 7'h00, 8'h00, 1, 0, 7'h12, 8'h00, 1, 8'h00, 8'hA5};
    vecs[2] = '{1, 1, 7'h20, 8'h3C, 1, 1, 7'h21, 8'hC3, 0, 8'h00, 8'hA5};
    vecs[3] = '{1, 0, 7'h21, 8'h00, 1, 0, 7'h20, 8'h00, 0, 8'hC3, 8'h3C};
    vecs[4] = '{0, 0, 7'h00, 8'h00, 1, 1, 7'h30, 8'h5A, 1, 8'hC3, 8'h3C};
    vecs[5] = '{1, 0, 7'h20, 8'h00, 0, 0, 7'h00, 8'h00, 0, 8'h3C, 8'h3C};
`ifdef SPI_PRIORITY_EN
    vecs[6] = '{1, 0, 7'h30, 8'h00, 1, 0, 7'h21, 8'h00, 0, 8'h5A, 8'hC3};
`else
    vecs[6] = '{1, 0, 7'h30, 8'h00, 1, 0, 7'h21, 8'h00, 1, 8'h5A, 8'hC3};
`endif

    // Reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_acks", {30'd0, spi_ack, host_ack}, 32'd0);
    chk("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_rdata", {16'd0, spi_rdata, host_rdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions
    prev_srd = 8'h00;
    prev_hrd = 8'h00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      spi_req = vecs[i].sr;   spi_we = vecs[i].sw;   spi_addr = vecs[i].sa;  spi_wdata = vecs[i].sd;
      host_req = vecs[i].hr;  host_we = vecs[i].hw;  host_addr = vecs[i].ha; host_wdata = vecs[i].hd;
      first_host = vecs[i].sr ? (vecs[i].hr ? vecs[i].host_first : 1'b0) : 1'b1;
      wait_ack(1, side, cyc);
      if (first_host) begin
        check_txn($sformatf("v%0d_a", i), side, cyc, 1, 2, vecs[i].hw, vecs[i].ha, vecs[i].hd);
        chk($sformatf("v%0d_a_host_rdata", i), {24'd0, host_rdata}, {24'd0, vecs[i].hrd});
        chk($sformatf("v%0d_a_spi_rdata", i), {24'd0, spi_rdata}, {24'd0, prev_srd});
      end else begin
        check_txn($sformatf("v%0d_a", i), side, cyc, 0, 2, vecs[i].sw, vecs[i].sa, vecs[i].sd);
        chk($sformatf("v%0d_a_spi_rdata", i), {24'd0, spi_rdata}, {24'd0, vecs[i].srd});
        chk($sformatf("v%0d_a_host_rdata", i), {24'd0, host_rdata}, {24'd0, prev_hrd});
      end
      if (vecs[i].sr && vecs[i].hr) begin
        wait_ack(1, side, cyc);
        if (first_host)
          check_txn($sformatf("v%0d_b", i), side, cyc, 0, 3, vecs[i].sw, vecs[i].sa, vecs[i].sd);
        else
          check_txn($sformatf("v%0d_b", i), side, cyc, 1, 3, vecs[i].hw, vecs[i].ha, vecs[i].hd);
        chk($sformatf("v%0d_b_spi_rdata", i), {24'd0, spi_rdata}, {24'd0, vecs[i].srd});
        chk($sformatf("v%0d_b_host_rdata", i), {24'd0, host_rdata}, {24'd0, vecs[i].hrd});
      end
      prev_srd = vecs[i].srd;
      prev_hrd = vecs[i].hrd;
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_idle_acks", i), {30'd0, spi_ack, host_ack}, 32'd0);
    end

    // Reset during ACCESS of a write
    @(negedge clk);
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 7'h40; spi_wdata = 8'h77;
    @(negedge clk);
    chk("rstmid_we_before", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_we_after", {31'd0, mem_we}, 32'd0);
    chk("rstmid_en_after", {31'd0, mem_en}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    spi_req = 1'b0; spi_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_noack%0d", k), {30'd0, spi_ack, host_ack}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_post_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_post_addr", {25'd0, mem_addr}, 32'd0);
    chk("rstmid_post_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rstmid_post_rdata", {16'd0, spi_rdata, host_rdata}, 32'd0);
    chk("rstmid_post_acks", {30'd0, spi_ack, host_ack}, 32'd0);

    // Address change during ACCESS must not affect the transaction in flight
    @(negedge clk);
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 7'h12; spi_wdata = 8'h11;
    @(negedge clk);
    spi_addr = 7'h34;
    #1;
    chk("addrchg_access_addr", {25'd0, mem_addr}, 32'h12);
    chk("addrchg_access_en", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    chk("addrchg_ack", {30'd0, spi_ack, host_ack}, 32'd2);
    chk("addrchg_resp_addr", {25'd0, mem_addr}, 32'h12);
    spi_req = 1'b0; spi_we = 1'b0;
    @(negedge clk);
    chk("addrchg_mem12", {24'd0, mem[7'h12]}, 32'h11);
    chk("addrchg_mem34", {24'd0, mem[7'h34]}, 32'h00);

    // Tie right after reset, then both requests held for four transactions
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef SPI_PRIORITY_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    spi_req = 1'b1;  spi_we = 1'b0;  spi_addr = 7'h12;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h20;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, side, cyc);
      chk($sformatf("held%0d_side", k), side, exp_seq[k]);
      chk($sformatf("held%0d_cyc", k), cyc, (k == 0) ? 2 : 3);
      if (k == 0) chk("held0_spi_rdata", {24'd0, spi_rdata}, 32'h11);
      if (k == 1 && exp_seq[1] == 1) chk("held1_host_rdata", {24'd0, host_rdata}, 32'h3C);
    end
    spi_req = 1'b0;
    wait_ack(1, side, cyc);
    chk("held_drop_side", side, 1);
    chk("held_drop_cyc", cyc, 3);
    chk("held_drop_host_rdata", {24'd0, host_rdata}, 32'h3C);
    host_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
